// File: rtl/axi4l_cmd_master.sv
// axi4l_cmd_master: turns single read/write commands into AXI4-Lite
// transactions, one outstanding at a time, and returns one response per
// command.
//
// Optional build macro: AXI4L_CMD_MASTER_TIMEOUT_EN. When defined, a cycle
// counter aborts any transaction that stays in the AXI phases for
// TIMEOUT_CYCLES cycles and reports rsp_resp = 2'b11 with zero data. When
// undefined there is no counter and the block waits forever on AXI handshakes.
//
// Handshake rule used on every channel (cmd, rsp, AW, W, B, AR, R): a transfer
// happens on a rising clock edge where valid and ready are both high. A valid
// never waits for ready, never drops before its transfer, and its payload is
// held stable while it is high.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 WR_REQ, 2 WR_RESP, 3 RD_REQ,
// 4 RD_RESP, 5 RSP.

module axi4l_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      axi4l_aclk,
  input  logic                      axi4l_arstn,
  // command side
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_wr,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response side
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AW channel
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // W channel
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // B channel
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  // AR channel
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  // R channel
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  // debug
  output logic [2:0]                dbg_state_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Elaboration-time parameter sanity checks.
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("axi4l_cmd_master: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4l_cmd_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  logic cmd_accept;
  logic aw_fire;
  logic w_fire;
  logic busy;
  logic timeout_hit;

  // Command acceptance is only possible in IDLE and never while reset is held.
  assign cmd_ready     = (state_q == IDLE) && !axi4l_arstn;
  assign cmd_accept    = cmd_valid && cmd_ready;

  // AXI valid/ready are pure functions of state and the per-channel done flags.
  assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_arvalid = (state_q == RD_REQ);
  assign m_axi_rready  = (state_q == RD_RESP);
  assign rsp_valid     = (state_q == RSP);

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;
  assign busy    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_RESP);

  // Address and write payload come straight from the command registers, so
  // they stay stable for the whole transaction. The address is not aligned.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign dbg_state_o  = state_q;

`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count busy cycles; cleared on each accepted command, saturating at the
  // last count so a late timeout still fires in the next busy state.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (cmd_accept) begin
      tmo_cnt_d = '0;
    end else if (busy && (tmo_cnt_q < TMO_LAST)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timeout_hit = busy && (tmo_cnt_q >= TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and datapath: a real handshake always wins over a timeout
  // landing in the same cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_wr ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in any order or together.
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b11;
          state_d     = RSP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b11;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          state_d = RD_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b11;
          state_d     = RSP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b11;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

endmodule

// File: doc/axi4l_cmd_master.md
AXI4L_CMD_MASTER -- requirements
Module: axi4l_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI and command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, 32 or 64 only.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: response timeout limit, in cycles.
REQ-004 SHALL have port axi4l_aclk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port axi4l_arstn  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_wr  in  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  in  ADDR_WIDTH  byte address.
REQ-010 SHALL have port cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 SHALL have port cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  out  1  response available.
REQ-013 SHALL have port rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-015 SHALL have port rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout.
REQ-016 SHALL have ports m_axi_awaddr (out, ADDR_WIDTH), m_axi_awvalid (out, 1), m_axi_awready (in, 1): AW channel.
REQ-017 SHALL have ports m_axi_wdata (out, DATA_WIDTH), m_axi_wstrb (out, DATA_WIDTH/8), m_axi_wvalid (out, 1), m_axi_wready (in, 1): W channel.
REQ-018 SHALL have ports m_axi_bresp (in, 2), m_axi_bvalid (in, 1), m_axi_bready (out, 1): B channel.
REQ-019 SHALL have ports m_axi_araddr (out, ADDR_WIDTH), m_axi_arvalid (out, 1), m_axi_arready (in, 1): AR channel.
REQ-020 SHALL have ports m_axi_rdata (in, DATA_WIDTH), m_axi_rresp (in, 2), m_axi_rvalid (in, 1), m_axi_rready (out, 1): R channel.

Function
REQ-021 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP, with one transaction outstanding at most.
REQ-022 SHALL drive cmd_ready high only in IDLE; on acceptance SHALL register address, data and strobes, then enter WR_REQ (cmd_wr=1) or RD_REQ.
REQ-023 SHALL, in WR_REQ, assert awvalid and wvalid in the first cycle (1 cycle after acceptance), hold each until its own ready is sampled high, handle AW and W accepted in the same cycle or in either order, then enter WR_RESP.
REQ-024 SHALL, in WR_RESP, assert bready, capture bresp on bvalid, set rsp_rdata=0, then enter RSP.
REQ-025 SHALL, in RD_REQ, assert arvalid until arready, then enter RD_RESP with rready high; capture rdata and rresp on rvalid, then enter RSP.
REQ-026 SHALL, in RSP, hold rsp_valid and its payload stable until rsp_ready, then return to IDLE; back-to-back commands SHALL be accepted no earlier than the cycle after the rsp handshake.
REQ-027 SHALL keep valid signals independent of ready, never deassert a valid before its handshake, and keep address/data stable while valid is high.
REQ-028 SHALL treat cmd_addr[1:0] as passed through unaltered (no alignment) and treat cmd_* as don't-care while cmd_ready is low.

Reset
REQ-029 SHALL, while axi4l_arstn is high, force state to IDLE and drive all valid/ready outputs, cmd_ready, rsp_valid, rsp_rdata and rsp_resp to 0; address/data outputs SHALL reset to 0.
REQ-030 SHALL abandon any in-flight transaction on reset with no response issued, and SHALL drive cmd_ready high the first cycle after reset deassertion.

Configuration
REQ-031 SHALL, with AXI4L_CMD_MASTER_TIMEOUT_EN defined, count cycles spent in WR_REQ/WR_RESP/RD_REQ/RD_RESP; on reaching TIMEOUT_CYCLES it SHALL drop all AXI valid/ready, enter RSP with rsp_resp=2'b11 and rsp_rdata=0, and clear the counter on each new command.
REQ-032 SHALL, without AXI4L_CMD_MASTER_TIMEOUT_EN, contain no counter and wait indefinitely for AXI handshakes.

Verification
REQ-033 SHALL be verified with: write addr 0x4, data 0xDEADBEEF, wstrb 0xF, with awready and wready high -> awvalid/wvalid rise 1 cycle after acceptance; bresp 0 -> rsp_resp 0, rsp_rdata 0.
REQ-034 SHALL be verified with: write where wready rises 3 cycles before awready -> wvalid drops after its handshake, awvalid held, exactly one AW and one W beat.
REQ-035 SHALL be verified with: read addr 0x8 with rdata 0x12345678 and rresp 2'b10 -> rsp_rdata 0x12345678, rsp_resp 2'b10.
REQ-036 SHALL be verified with: rsp_ready held low 5 cycles -> rsp_valid and payload stable, cmd_ready low throughout.
REQ-037 SHALL be verified with: macro defined, TIMEOUT_CYCLES=16, arready held low -> rsp_resp 2'b11 after 16 cycles, arvalid 0.
REQ-038 SHALL be verified with: reset asserted during WR_RESP -> all outputs 0 immediately, no rsp_valid, cmd_ready 1 after release.
